// File: rtl/serial_pattern_sender_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_sender_pkg
// Shared types and helpers for the serial pattern sender.
//   state_e      : frame FSM states (IDLE, SEND)
//   clamp_length : limits a requested frame length to the pattern width
// -----------------------------------------------------------------------------
package serial_pattern_sender_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Returns min(length, max_len). Lengths above the pattern width would
    // otherwise shift in zeros past the end of the captured pattern.
    function automatic int unsigned clamp_length(input int unsigned length,
                                                 input int unsigned max_len);
        return (length > max_len) ? max_len : length;
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// -----------------------------------------------------------------------------
// strobe_gen
// Free-running bit-rate counter. While enabled it counts modulo
// 2^strobe_width and raises strobe for the one cycle where the count is at
// its maximum, giving one strobe every 2^strobe_width clocks.
//   clk     in  : system clock
//   reset_n in  : asynchronous active-low reset
//   clear   in  : restart the count from zero (frame start)
//   enable  in  : advance the count
//   strobe  out : one-cycle pulse at the end of each bit period
// -----------------------------------------------------------------------------
module strobe_gen #(
    parameter int strobe_width = 23
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic strobe
);

    logic [strobe_width-1:0] cnt_q;
    logic [strobe_width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // Wraps naturally modulo 2^strobe_width.
            cnt_d = cnt_q + strobe_width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = enable && (cnt_q == '1);

endmodule

// File: rtl/serial_pattern_sender.sv
// -----------------------------------------------------------------------------
// serial_pattern_sender
// Captures a parallel pattern on a load request and emits it MSB-first, one
// bit per strobe period, with a one-cycle valid pulse per bit. Optionally
// repeats the frame continuously (cyclic mode).
//   clk       in  : system clock
//   reset_n   in  : asynchronous active-low reset
//   load      in  : start a frame (ignored while busy or when length is 0)
//   data      in  : pattern, bit width-1 is sent first
//   length    in  : number of bits to send from the MSB (clamped to width)
//   cyclic    in  : restart the frame after its last bit (sampled at last bit)
//   abort     in  : stop the current frame; wins over a simultaneous load
//   out_bit   out : current serial bit (holds between pulses)
//   out_valid out : one-cycle pulse per new bit
//   busy      out : frame active; stays high through the done cycle
//   done      out : one-cycle pulse with the last bit of each frame
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_pattern_sender
    import serial_pattern_sender_pkg::*;
#(
    parameter int width        = 8,
    parameter int strobe_width = 23
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic [width-1:0]             data,
    input  logic [$clog2(width+1)-1:0]   length,
    input  logic                         cyclic,
    input  logic                         abort,
    output logic                         out_bit,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(width + 1);

    state_e             state_q, state_d;
    logic [width-1:0]   shift_q, shift_d;
    logic [width-1:0]   shadow_q, shadow_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               out_bit_q, out_bit_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               strobe;
    logic               accept;
    logic               emit;
    logic               last_bit;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = LEN_W'(clamp_length(32'(length), 32'(width)));

    // busy_q also covers the done cycle, so gating on it keeps a load in
    // that cycle from being accepted while busy still reads 1.
    assign accept   = (state_q == IDLE) && load && !abort && !busy_q
                      && (length != '0);
    assign emit     = (state_q == SEND) && strobe && !abort;
    assign last_bit = emit && (bit_cnt_q == LEN_W'(1));

    strobe_gen #(
        .strobe_width (strobe_width)
    ) u_strobe_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (state_q == SEND),
        .strobe  (strobe)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit && !cyclic) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values of output registers) ----------------
    always_comb begin
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        if (emit) begin
            out_bit_d   = shift_q[width-1];
            out_valid_d = 1'b1;
            done_d      = last_bit;
        end
        busy_d = (state_d == SEND) || done_d;
    end

    // ---------------- Datapath: shift / shadow / length / bit counter ----------------
    always_comb begin
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shift_d   = data;
            shadow_d  = data;
            len_d     = len_clamped;
            bit_cnt_d = len_clamped;
        end else if (emit) begin
            if (last_bit && cyclic) begin
                // Reload for the next frame; the strobe counter keeps running
                // so the next bit follows one period later with no gap.
                shift_d   = shadow_q;
                bit_cnt_d = len_q;
            end else begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= '0;
            shadow_q    <= '0;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
